// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: the active-low segment
// codes of our hex encoder (bit0=a .. bit6=g), error flag positions, and the
// small types passed between the decoder blocks.
package seg7_pkg;

    // Active-low segment codes, identical to the hex encoder table.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Bit positions inside the sticky error vector.
    localparam int ERR_PATTERN = 0;
    localparam int ERR_SELECT  = 1;

    // Result of looking up one segment pattern.
    typedef struct packed {
        logic       legal;   // one of the 16 encoder codes
        logic       blank;   // all segments off
        logic [3:0] nibble;  // decoded value, meaningful only when legal
    } seg_decode_t;

    // Classification of the digit-enable bus.
    typedef enum logic [1:0] {
        SEL_IDLE,   // no digit driven
        SEL_ONE,    // exactly one digit driven
        SEL_MULTI   // bus contention: several digits driven at once
    } sel_kind_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display bus plus decoded results of the scan decoder. The master side is
// whatever drives the multiplexed display (a bench or the board loopback);
// the slave side is the decoder itself.
interface seg7_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg_n;        // shared active-low segment bus
    logic [NDIG-1:0]   an_n;         // active-low digit enables
    logic              clr_err;      // clear sticky error flags
    logic [4*NDIG-1:0] hex_out;      // decoded nibbles, digit i at [4i+3:4i]
    logic [NDIG-1:0]   digit_valid;  // digit holds a legally decoded value
    logic              update;       // pulse on every capture
    logic              frame_done;   // pulse once all digits captured
    logic [1:0]        err;          // sticky {multi-select, illegal pattern}

    modport master (
        output seg_n, an_n, clr_err,
        input  hex_out, digit_valid, update, frame_done, err
    );

    modport slave (
        input  seg_n, an_n, clr_err,
        output hex_out, digit_valid, update, frame_done, err
    );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex encoder: maps an active-low segment
// pattern back to its nibble and flags blank or unrecognised patterns.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0]  seg_n,
    output seg_decode_t dec
);

    // Table lookup; anything outside the encoder table and blank is illegal.
    always_comb begin
        // NOTE: every field gets a value before the case so no path leaves
        // an output unassigned, which would otherwise infer a latch.
        dec.legal  = 1'b1;
        dec.blank  = 1'b0;
        dec.nibble = 4'h0;
        case (seg_n)
            SEG_0:     dec.nibble = 4'h0;
            SEG_1:     dec.nibble = 4'h1;
            SEG_2:     dec.nibble = 4'h2;
            SEG_3:     dec.nibble = 4'h3;
            SEG_4:     dec.nibble = 4'h4;
            SEG_5:     dec.nibble = 4'h5;
            SEG_6:     dec.nibble = 4'h6;
            SEG_7:     dec.nibble = 4'h7;
            SEG_8:     dec.nibble = 4'h8;
            SEG_9:     dec.nibble = 4'h9;
            SEG_A:     dec.nibble = 4'hA;
            SEG_B:     dec.nibble = 4'hB;
            SEG_C:     dec.nibble = 4'hC;
            SEG_D:     dec.nibble = 4'hD;
            SEG_E:     dec.nibble = 4'hE;
            SEG_F:     dec.nibble = 4'hF;
            SEG_BLANK: begin
                dec.legal = 1'b0;
                dec.blank = 1'b1;
            end
            default:   dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for a time-multiplexed active-low 7-segment display bus.
// The bus is double-synchronised, a sample must stay unchanged for
// STABLE_CYCLES consecutive clocks before it is trusted, and the trusted
// pattern is decoded and stored against the single digit being driven.
// Contention and unknown patterns raise sticky error flags.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG          = 4,   // 1..8 multiplexed digits
    parameter int STABLE_CYCLES = 4    // 2..255 identical samples before capture
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int         SAMPLE_W = NDIG + 7;
    localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);

    // Synchroniser stages; s3 is the previous s2 used for change detection.
    logic [SAMPLE_W-1:0] s1, s2, s3;

    // Run-length of the current s2 value, saturating at RUN_MAX.
    logic [7:0]          run_cnt;
    logic                run_reached;

    // Select classification and segment decode of the trusted sample.
    logic [NDIG-1:0]     sel;
    sel_kind_e           sel_kind;
    seg_decode_t         dec;
    logic                capture;

    // Registered state and outputs.
    logic [NDIG-1:0][3:0] hex_q;
    logic [NDIG-1:0]      valid_q;
    logic [NDIG-1:0]      mask_q;
    logic [NDIG-1:0]      mask_acc;
    logic                 update_q;
    logic                 frame_q;
    logic [1:0]           err_q;
    logic [1:0]           err_set;

    // Two-flop synchroniser plus one history stage; idle (all ones) on reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours and the chain shifts
        // by exactly one stage per clock.
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= {bus.an_n, bus.seg_n};
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Count how long s2 has held its value; restart at 1 on any change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (s2 != s3) begin
            run_cnt <= 8'd1;
        end else if (run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + 8'd1;
        end
    end

    // The run reaches its threshold on this edge exactly once per held value.
    assign run_reached = (s2 == s3) && (run_cnt == RUN_MAX - 8'd1);

    // Classify the digit enables of the trusted sample.
    always_comb begin
        sel = ~s2[SAMPLE_W-1:7];
        if (sel == '0) begin
            sel_kind = SEL_IDLE;
        end else if ($onehot(sel)) begin
            sel_kind = SEL_ONE;
        end else begin
            sel_kind = SEL_MULTI;
        end
    end

    seg7_to_hex u_seg7_to_hex (
        .seg_n (s2[6:0]),
        .dec   (dec)
    );

    assign capture = run_reached && (sel_kind == SEL_ONE);

    // Next frame mask and error set requests for this edge.
    always_comb begin
        mask_acc               = mask_q | sel;
        err_set                = '0;
        err_set[ERR_PATTERN]   = capture && !dec.legal && !dec.blank;
        err_set[ERR_SELECT]    = run_reached && (sel_kind == SEL_MULTI);
    end

    // Per-digit storage, capture pulses, frame tracking and sticky errors.
    always_ff @(posedge clk) begin
        // NOTE: the per-digit storage is cleared by reset because the
        // decoded value is architecturally visible at hex_out from reset on.
        if (!rst_n) begin
            hex_q    <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            update_q <= 1'b0;
            frame_q  <= 1'b0;
            if (capture) begin
                update_q <= 1'b1;
                for (int i = 0; i < NDIG; i++) begin
                    if (sel[i]) begin
                        valid_q[i] <= dec.legal;
                        if (dec.legal) begin
                            hex_q[i] <= dec.nibble;
                        end
                    end
                end
                if (&mask_acc) begin
                    frame_q <= 1'b1;
                    mask_q  <= '0;
                end else begin
                    mask_q  <= mask_acc;
                end
            end
            // A fresh error on the clearing edge survives the clear.
            err_q <= (bus.clr_err ? 2'b00 : err_q) | err_set;
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.digit_valid = valid_q;
    assign bus.update      = update_q;
    assign bus.frame_done  = frame_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder (NDIG=4, STABLE_CYCLES=4). Directed scenarios
// followed by randomised scanning; every clock the DUT outputs are compared
// with a reference model that reasons over the history of applied samples.
module tb_seg7_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_decoder_if #(.NDIG(NDIG)) bus ();

    seg7_scan_decoder #(
        .NDIG          (NDIG),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Encoder table written out independently of the design package.
    logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp = 0;
    int n_bad = 0;
    int n_upd = 0;
    int n_fd  = 0;

    // Reference model state.
    logic [3:0]      m_hex [NDIG];
    logic [NDIG-1:0] m_valid;
    logic [NDIG-1:0] m_mask;
    logic            m_upd;
    logic            m_fd;
    logic [1:0]      m_err;
    logic [10:0]     hist [$];   // {an_n, seg_n} sampled at each edge, oldest first

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) m_hex[i] = 4'h0;
        m_valid = '0;
        m_mask  = '0;
        m_upd   = 1'b0;
        m_fd    = 1'b0;
        m_err   = 2'b00;
        hist.delete();
        repeat (8) hist.push_back(11'h7FF);
    endtask

    // Effect of one clock edge. A pattern is acted on two edges after it has
    // been sampled for the STABLE-th time in a row.
    task automatic model_edge(input logic rst, input logic [3:0] an,
                              input logic [6:0] seg, input logic clr);
        int          idx;
        int          run;
        int          j;
        int          nlow;
        int          d;
        int          code;
        logic [10:0] cur;
        logic [1:0]  set;
        if (!rst) begin
            model_reset();
            return;
        end
        m_upd = 1'b0;
        m_fd  = 1'b0;
        set   = 2'b00;
        idx   = hist.size() - 2;
        cur   = hist[idx];
        run   = 1;
        j     = idx - 1;
        while (j >= 0 && hist[j] === cur && run <= STABLE) begin
            run++;
            j--;
        end
        if (run == STABLE) begin
            nlow = 0;
            d    = 0;
            for (int i = 0; i < NDIG; i++) begin
                if (!cur[7+i]) begin
                    nlow++;
                    d = i;
                end
            end
            if (nlow > 1) begin
                set[1] = 1'b1;
            end else if (nlow == 1) begin
                m_upd = 1'b1;
                code  = -1;
                for (int k = 0; k < 16; k++) if (enc[k] == cur[6:0]) code = k;
                if (code >= 0) begin
                    m_hex[d]   = 4'(code);
                    m_valid[d] = 1'b1;
                end else begin
                    m_valid[d] = 1'b0;
                    if (cur[6:0] != 7'h7F) set[0] = 1'b1;
                end
                m_mask[d] = 1'b1;
                if (m_mask == '1) begin
                    m_fd   = 1'b1;
                    m_mask = '0;
                end
            end
        end
        m_err = (clr ? 2'b00 : m_err) | set;
        hist.push_back({an, seg});
        if (hist.size() > 24) void'(hist.pop_front());
    endtask

    // Apply one clock worth of stimulus, advance the model, compare outputs.
    task automatic tick(input logic [3:0] an, input logic [6:0] seg,
                        input logic clr = 1'b0, input logic rst = 1'b1);
        logic [15:0] exp_hex;
        bus.an_n    = an;
        bus.seg_n   = seg;
        bus.clr_err = clr;
        rst_n       = rst;
        @(posedge clk);
        model_edge(rst, an, seg, clr);
        #1;
        for (int i = 0; i < NDIG; i++) exp_hex[4*i +: 4] = m_hex[i];
        check("hex_out",     32'(bus.hex_out),     32'(exp_hex));
        check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
        check("update",      32'(bus.update),      32'(m_upd));
        check("frame_done",  32'(bus.frame_done),  32'(m_fd));
        check("err",         32'(bus.err),         32'(m_err));
        if (bus.update)     n_upd++;
        if (bus.frame_done) n_fd++;
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) tick(an, seg);
    endtask

    initial begin
        int          u0;
        int          f0;
        int          pos;
        int          nz;
        int          len;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [3:0]  scan_val [4];
        logic [15:0] hx;

        model_reset();
        bus.an_n    = 4'hF;
        bus.seg_n   = 7'h7F;
        bus.clr_err = 1'b0;

        // 1: reset held for three edges
        repeat (3) tick(4'hF, 7'h7F, 1'b0, 1'b0);
        check("rst_hex",   32'(bus.hex_out),     32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_err",   32'(bus.err),         32'h0);
        dwell(4'hF, 7'h7F, 3);

        // 2: round trip of all 16 codes on digit 0, capture on the sixth edge
        for (int k = 0; k < 16; k++) begin
            u0  = n_upd;
            pos = 0;
            for (int t = 1; t <= 8; t++) begin
                tick(4'b1110, enc[k]);
                if (bus.update) pos = t;
            end
            check("rt_updates", 32'(n_upd - u0), 32'd1);
            check("rt_latency", 32'(pos), 32'd6);
            hx = bus.hex_out;
            check("rt_nibble", 32'(hx[3:0]), 32'(k));
            check("rt_valid",  32'(bus.digit_valid[0]), 32'd1);
        end

        // 3: short glitch of 8 followed by a held 3
        u0 = n_upd;
        dwell(4'b1110, enc[8], 3);
        dwell(4'b1110, enc[3], 6);
        dwell(4'hF, 7'h7F, 2);
        check("glitch_updates", 32'(n_upd - u0), 32'd1);
        hx = bus.hex_out;
        check("glitch_nibble", 32'(hx[3:0]), 32'h3);

        // 4: two full scans of 2,0,2,5
        scan_val = '{4'h2, 4'h0, 4'h2, 4'h5};
        for (int s = 0; s < 2; s++) begin
            f0 = n_fd;
            for (int d = 0; d < 4; d++) dwell(~(4'b0001 << d), enc[scan_val[d]], 6);
            dwell(4'hF, 7'h7F, 2);
            check("scan_frames", 32'(n_fd - f0), 32'd1);
            check("scan_hex", 32'(bus.hex_out), 32'h5202);
        end

        // 5: illegal pattern, contention, then clear
        dwell(4'b1101, 7'b1010101, 6);
        check("bad_pat_err",   32'(bus.err), 32'h1);
        check("bad_pat_valid", 32'(bus.digit_valid[1]), 32'd0);
        u0 = n_upd;
        dwell(4'b1100, enc[1], 6);
        check("multi_err",     32'(bus.err), 32'h3);
        check("multi_updates", 32'(n_upd - u0), 32'd0);
        tick(4'hF, 7'h7F, 1'b1);
        check("clr_err", 32'(bus.err), 32'h0);

        // 6: blank digit, then reset partway through a dwell
        dwell(4'b1011, 7'h7F, 6);
        check("blank_valid", 32'(bus.digit_valid[2]), 32'd0);
        check("blank_err",   32'(bus.err), 32'h0);
        dwell(4'b0111, enc[7], 2);
        tick(4'hF, 7'h7F, 1'b0, 1'b0);
        u0 = n_upd;
        dwell(4'hF, 7'h7F, 8);
        check("midrst_updates", 32'(n_upd - u0), 32'd0);
        check("midrst_hex",     32'(bus.hex_out), 32'h0);
        check("midrst_valid",   32'(bus.digit_valid), 32'h0);

        // Randomised scanning with contention, bad codes, clears and resets
        for (int r = 0; r < 400; r++) begin
            case ($urandom_range(0, 9))
                0:       an = 4'hF;
                1: begin
                    do begin
                        an = 4'($urandom);
                        nz = 0;
                        for (int i = 0; i < 4; i++) if (!an[i]) nz++;
                    end while (nz < 2);
                end
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 9))
                0:       seg = 7'h7F;
                1:       seg = 7'($urandom);
                default: seg = enc[$urandom_range(0, 15)];
            endcase
            len = $urandom_range(1, 8);
            for (int t = 0; t < len; t++) begin
                tick(an, seg, ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 299) != 0));
            end
        end
        dwell(4'hF, 7'h7F, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
